wb_line_responder: RTL



---
 rtl/wb_pkg.sv | 31 +++
 rtl/wb_line_store.sv | 36 +++
 rtl/wb_line_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_pkg
// Shared line/byte-enable types, FSM encoding and byte-merge helper.
// Rev    : 1.0 initial release
// ============================================================================
package wb_pkg;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned SEL_W  = 16;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  function automatic line_t merge_line(input line_t old_line, input line_t new_line,
                                       input logic [SEL_W-1:0] sel);
    line_t res;
    res = old_line;
    for (int i = 0; i < SEL_W; i++) begin
      if (sel[i]) res[i*8 +: 8] = new_line[i*8 +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_line_store.sv
`default_nettype none
// ============================================================================
// Module : wb_line_store
// Single-port line array: synchronous byte-enabled write, combinational read.
// Rev    : 1.0 initial release
// ============================================================================
module wb_line_store
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter line_t       INIT_PATTERN = '0
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [SEL_W-1:0]      i_sel,
  input  line_t                 i_wdata,
  output line_t                 o_rdata
);

  localparam int unsigned C_DEPTH = 2 ** DEPTH_LOG2;

  // Lines are held XOR-ed with INIT_PATTERN, so a zero-initialised array
  // reads back as INIT_PATTERN without any preload or reset.
  line_t r_mem [C_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= merge_line(r_mem[i_addr], i_wdata ^ INIT_PATTERN, i_sel);
    end
  end

  assign o_rdata = r_mem[i_addr] ^ INIT_PATTERN;

endmodule
`default_nettype wire

// File: rtl/wb_line_responder.sv
`default_nettype none
// ============================================================================
// Module : wb_line_responder
// Wishbone line responder with programmable latency; optional WB_RETRY_EN
// adds LFSR-driven RTY responses.
// Rev    : 1.0 initial release
// ============================================================================
module wb_line_responder
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 28,
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned LATENCY      = 4,
  parameter line_t       INIT_PATTERN = 128'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CYC,
  input  logic              STB,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADR,
  input  logic [SEL_W-1:0]  SEL,
  input  line_t             DAT_M,
  output line_t             DAT_S,
  output logic              ACK,
  output logic              RTY
);

  localparam logic [3:0] c_cnt_load = 4'(LATENCY - 1);

  wb_state_e             r_state, w_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_we;
  logic [SEL_W-1:0]      r_sel;
  line_t                 r_dat_m;
  line_t                 r_dat_s;
  logic                  w_req, w_accept, w_load_dat, w_retry_hit, w_retry;
  logic [DEPTH_LOG2-1:0] w_addr;
  logic                  w_store_we;
  line_t                 w_rd_line;
  logic                  w_unused;

  assign w_req    = CYC & STB;
  assign w_unused = ^ADR[ADDR_W-1:DEPTH_LOG2];

`ifdef WB_RETRY_EN
  logic [15:0] r_lfsr;
  logic        r_retry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= 16'hACE1;
      r_retry <= 1'b0;
    end else if (w_accept) begin
      r_lfsr  <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      r_retry <= w_retry_hit;
    end
  end

  assign w_retry_hit = (r_lfsr[2:0] == 3'b000);
  assign w_retry     = r_retry;
`else
  assign w_retry_hit = 1'b0;
  assign w_retry     = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    w_load_dat = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          if (w_retry_hit || (LATENCY == 1)) begin
            w_next     = RESP;
            w_cnt_next = 4'd0;
            w_load_dat = !WE && !w_retry_hit;
          end else begin
            w_next     = WAIT;
            w_cnt_next = c_cnt_load;
          end
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_next     = IDLE;
          w_cnt_next = 4'd0;
        end else begin
          // Enter RESP on the edge where the count reaches zero.
          w_cnt_next = r_cnt - 4'd1;
          if (w_cnt_next == 4'd0) begin
            w_next     = RESP;
            w_load_dat = !r_we;
          end
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_dat_m <= '0;
      r_dat_s <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_idx   <= ADR[DEPTH_LOG2-1:0];
        r_we    <= WE;
        r_sel   <= SEL;
        r_dat_m <= DAT_M;
      end
      if (w_load_dat) r_dat_s <= w_rd_line;
    end
  end

  // Live address while idle so a LATENCY=1 read sees the array immediately.
  assign w_addr     = (r_state == IDLE) ? ADR[DEPTH_LOG2-1:0] : r_idx;
  assign w_store_we = (r_state == RESP) && r_we && !w_retry;

  wb_line_store #(
    .DEPTH_LOG2   (DEPTH_LOG2),
    .INIT_PATTERN (INIT_PATTERN)
  ) u_store (
    .clk     (clk),
    .i_we    (w_store_we),
    .i_addr  (w_addr),
    .i_sel   (r_sel),
    .i_wdata (r_dat_m),
    .o_rdata (w_rd_line)
  );

  assign DAT_S = r_dat_s;
  assign ACK   = (r_state == RESP) && !w_retry;
  assign RTY   = (r_state == RESP) && w_retry;

endmodule
`default_nettype wire
